cic_comb_chain: RTL and testbench
=================================

CIC_COMB_CHAIN -- requirements
Module: cic_comb_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: two's-complement sample width of input, output and all internal registers.
REQ-002 The block SHALL have parameter STAGES, default 3: number of cascaded comb stages, legal range 1..8.
REQ-003 The block SHALL have parameter DELAY, default 1: differential delay M in samples per stage, legal range 1..4.
REQ-004 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port ena, input, 1 bit: global clock enable; low freezes all state.
REQ-007 Port in_valid, input, 1 bit: x_in carries a decimated sample this cycle.
REQ-008 Port x_in, input, WIDTH bits: signed input sample.
REQ-009 Port y_out, output, WIDTH bits: signed filtered sample.
REQ-010 Port out_valid, output, 1 bit: y_out updated this cycle; single-cycle strobe per sample.
REQ-011 Port flush, input, 1 bit: present only when CIC_COMB_FLUSH_EN is defined (see Configuration).

Function
REQ-012 Stage k SHALL compute d_k[n] = u_k[n] - u_k[n-DELAY], with u_0 = x_in and u_k = d_(k-1).
REQ-013 Indices SHALL count accepted samples, not clocks; each stage's delay line SHALL shift only when that stage's input valid and ena are both high.
REQ-014 A sample SHALL be accepted when ena=1 and in_valid=1; x_in=0 is valid data and SHALL be processed like any other value.
REQ-015 Each stage SHALL be one register stage; a per-stage valid bit SHALL travel with the data.
REQ-016 Latency SHALL be exactly STAGES enabled clocks from acceptance to out_valid=1 with the result on y_out.
REQ-017 Back-to-back in_valid on every cycle SHALL be supported at full throughput, no bubbles.
REQ-018 Subtraction SHALL be modulo 2^WIDTH (wrap-around, no saturation, no bit growth); the CIC gain is absorbed by the integrator-side width.
REQ-019 With ena=0, every register, including valid bits and delay lines, SHALL hold; out_valid SHALL be forced to 0 for that cycle and reassert with the held value when ena returns.
REQ-020 y_out SHALL hold its last value between out_valid strobes.
REQ-021 The delay lines SHALL start zero, so the first DELAY outputs of each stage equal its input minus 0.

Reset
REQ-022 reset=0 SHALL asynchronously clear y_out, out_valid, all stage data registers, valid bits and delay-line entries to 0.
REQ-023 A sample in flight at reset assertion SHALL be discarded, with no out_valid for it after release.
REQ-024 After release, the first sample accepted on the first enabled clock SHALL behave as in REQ-016 and REQ-021.

Configuration
REQ-025 The macro CIC_COMB_FLUSH_EN, when defined, SHALL add the flush port.
REQ-026 flush=1 with ena=1 SHALL synchronously zero all delay lines, valid bits, y_out and out_valid on the next edge; flush SHALL take priority over a simultaneous in_valid, and that sample is dropped.
REQ-027 flush=1 with ena=0 SHALL have no effect.
REQ-028 Without CIC_COMB_FLUSH_EN, the port SHALL be absent and only reset clears state.

Verification
REQ-029 Impulse test (STAGES=3, DELAY=1, WIDTH=16): inputs 1,0,0,0,0 on consecutive cycles -> outputs 1,-3,3,-1,0, the first three cycles after the 1.
REQ-030 Step with gaps (STAGES=1, DELAY=2): 5,5,5,5 with in_valid on alternate cycles -> outputs 5,5,0,0, each 1 cycle after its input.
REQ-031 Wrap test (STAGES=1, DELAY=1, WIDTH=8): 0x80 then 0x7F -> 0x80 then 0xFF.
REQ-032 Stall test: ena=0 for 4 cycles mid-stream of impulse test -> no out_valid during stall; sequence 1,-3,3,-1 intact afterwards, shifted 4 cycles.
REQ-033 Reset test: reset pulsed low between samples 2 and 3 of impulse test -> all outputs 0 immediately; next input 7 yields 7 as the first output.
REQ-034 Flush test (CIC_COMB_FLUSH_EN defined): flush coincident with in_valid, x_in=9 -> no out_valid for 9; next input 4 yields 4 (STAGES=1).

Source files
------------

// File: rtl/cic_comb_chain.sv
// cic_comb_chain -- cascade of CIC comb (differentiator) stages for the
// decimated side of a CIC decimator.
//
// Each stage k computes d_k[n] = u_k[n] - u_k[n-DELAY], where u_0 is x_in and
// u_k is the output of stage k-1. Indices count accepted samples, not clocks:
// a stage's delay line shifts only when its input is valid and ena is high.
// Arithmetic wraps modulo 2^WIDTH. The integrator side carries the CIC gain,
// so the comb side needs no bit growth.
//
// Parameters:
//   WIDTH  - two's-complement sample width of input, output and all registers
//   STAGES - number of cascaded comb stages (1..8)
//   DELAY  - differential delay M per stage, in samples (1..4)
//
// Ports:
//   clock     - single clock; all state changes on its rising edge
//   reset     - asynchronous, active-low; clears all state
//   ena       - global clock enable; low freezes every register
//   in_valid  - x_in carries a sample this cycle
//   x_in      - signed input sample
//   flush     - synchronous clear of pipeline and delay lines (only when
//               CIC_COMB_FLUSH_EN is defined); ignored while ena is low
//   y_out     - signed filtered sample; holds between out_valid strobes
//   out_valid - single-cycle strobe marking a new y_out (latency STAGES)
//
// Build option: define CIC_COMB_FLUSH_EN to add the flush port.

module cic_comb_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int DELAY  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x_in,
`ifdef CIC_COMB_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid
);

  // Modulo-2^WIDTH difference: the result is truncated to WIDTH bits, so
  // overflow wraps instead of saturating.
  function automatic logic signed [WIDTH-1:0] wrap_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a - b;
  endfunction

  // Inter-stage links. Index 0 is the chain input; index k+1 is the output
  // of stage k.
  logic signed [WIDTH-1:0] stg_d [STAGES+1];
  logic                    stg_v [STAGES+1];
  logic                    clr;

  assign stg_d[0] = x_in;
  assign stg_v[0] = in_valid;

`ifdef CIC_COMB_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic signed [WIDTH-1:0] data_p;
    logic                    vld_p;
    // dly_p[0] is the most recent accepted input; dly_p[DELAY-1] is u[n-DELAY].
    logic signed [WIDTH-1:0] dly_p [DELAY];

    // Stage boundary: one register per comb stage.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        data_p <= '0;
        vld_p  <= 1'b0;
        for (int i = 0; i < DELAY; i++) dly_p[i] <= '0;
      end else if (ena) begin
        if (clr) begin
          // Flush overrides a coincident input sample, which is dropped.
          data_p <= '0;
          vld_p  <= 1'b0;
          for (int i = 0; i < DELAY; i++) dly_p[i] <= '0;
        end else begin
          vld_p <= stg_v[k];
          if (stg_v[k]) begin
            data_p   <= wrap_sub(stg_d[k], dly_p[DELAY-1]);
            dly_p[0] <= stg_d[k];
            for (int i = 1; i < DELAY; i++) dly_p[i] <= dly_p[i-1];
          end
        end
      end
    end

    assign stg_d[k+1] = data_p;
    assign stg_v[k+1] = vld_p;
  end

  // The last stage register is the output. Its valid bit holds through a
  // stall, so the strobe is masked by ena and fires again when ena returns.
  assign y_out     = stg_d[STAGES];
  assign out_valid = stg_v[STAGES] & ena;

endmodule

// File: tb/tb_cic_comb_chain.sv
module tb_cic_comb_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic        flush;
  // Instance A: WIDTH 16, STAGES 3, DELAY 1
  logic        va;
  logic [15:0] xa;
  logic [15:0] ya;
  logic        ova;
  // Instance B: WIDTH 16, STAGES 1, DELAY 2
  logic        vb;
  logic [15:0] xb;
  logic [15:0] yb;
  logic        ovb;
  // Instance C: WIDTH 8, STAGES 1, DELAY 1
  logic        vc;
  logic [7:0]  xc;
  logic [7:0]  yc;
  logic        ovc;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comb_chain #(.WIDTH(16), .STAGES(3), .DELAY(1)) dut_a (
    .clock(clk), .reset(reset), .ena(ena), .in_valid(va), .x_in(xa),
`ifdef CIC_COMB_FLUSH_EN
    .flush(flush),
`endif
    .y_out(ya), .out_valid(ova)
  );

  cic_comb_chain #(.WIDTH(16), .STAGES(1), .DELAY(2)) dut_b (
    .clock(clk), .reset(reset), .ena(ena), .in_valid(vb), .x_in(xb),
`ifdef CIC_COMB_FLUSH_EN
    .flush(flush),
`endif
    .y_out(yb), .out_valid(ovb)
  );

  cic_comb_chain #(.WIDTH(8), .STAGES(1), .DELAY(1)) dut_c (
    .clock(clk), .reset(reset), .ena(ena), .in_valid(vc), .x_in(xc),
`ifdef CIC_COMB_FLUSH_EN
    .flush(flush),
`endif
    .y_out(yc), .out_valid(ovc)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one sample for one cycle. lat < 0 means no output is expected.
  task automatic put_a(input int x, input int y, input int lat);
    va = 1'b1;
    xa = x[15:0];
    if (lat >= 0) qa.push_back('{val: y, cyc: cyc + lat});
    step();
    va = 1'b0;
  endtask

  task automatic put_b(input int x, input int y, input int lat);
    vb = 1'b1;
    xb = x[15:0];
    if (lat >= 0) qb.push_back('{val: y, cyc: cyc + lat});
    step();
    vb = 1'b0;
  endtask

  task automatic put_c(input int x, input int y, input int lat);
    vc = 1'b1;
    xc = x[7:0];
    if (lat >= 0) qc.push_back('{val: y, cyc: cyc + lat});
    step();
    vc = 1'b0;
  endtask

  // Monitor: every out_valid strobe must match the head of its queue in both
  // value and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && ova) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected: got y=%0d at cyc %0d, expected no strobe", $signed(ya), cyc);
        end else begin
          e = qa.pop_front();
          if (ya !== e.val[15:0] || cyc != e.cyc) begin
            errors++;
            $display("FAIL a_out: got %0d at cyc %0d expected %0d at cyc %0d", $signed(ya), cyc, $signed(e.val[15:0]), e.cyc);
          end
        end
      end
      if (reset && ovb) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got y=%0d at cyc %0d, expected no strobe", $signed(yb), cyc);
        end else begin
          e = qb.pop_front();
          if (yb !== e.val[15:0] || cyc != e.cyc) begin
            errors++;
            $display("FAIL b_out: got %0d at cyc %0d expected %0d at cyc %0d", $signed(yb), cyc, $signed(e.val[15:0]), e.cyc);
          end
        end
      end
      if (reset && ovc) begin
        checks++;
        if (qc.size() == 0) begin
          errors++;
          $display("FAIL c_unexpected: got y=0x%02h at cyc %0d, expected no strobe", yc, cyc);
        end else begin
          e = qc.pop_front();
          if (yc !== e.val[7:0] || cyc != e.cyc) begin
            errors++;
            $display("FAIL c_out: got 0x%02h at cyc %0d expected 0x%02h at cyc %0d", yc, cyc, e.val[7:0], e.cyc);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    ena   = 1'b1;
    flush = 1'b0;
    va = 1'b0; xa = '0;
    vb = 1'b0; xb = '0;
    vc = 1'b0; xc = '0;
    repeat (2) step();

    // Reset state
    chk("rst_a_y", int'(ya), 0);
    chk("rst_a_ov", int'(ova), 0);
    chk("rst_b_y", int'(yb), 0);
    chk("rst_b_ov", int'(ovb), 0);
    chk("rst_c_y", int'(yc), 0);
    chk("rst_c_ov", int'(ovc), 0);
    reset = 1'b1;
    step();

    // Impulse, 3 stages, M=1: 1,0,0,0,0 -> 1,-3,3,-1,0 three cycles later
    put_a(1, 1, 3);
    put_a(0, -3, 3);
    put_a(0, 3, 3);
    put_a(0, -1, 3);
    put_a(0, 0, 3);
    repeat (5) step();

    // Same impulse with a 4-cycle stall after the third sample. The first
    // output is already in the last register when the stall starts, so it
    // must be withheld and then strobed once ena returns.
    put_a(1, 1, 7);
    put_a(0, -3, 7);
    put_a(0, 3, 7);
    ena = 1'b0;
    va  = 1'b1;
    xa  = 16'd55;        // must be ignored while ena is low
    repeat (4) step();
    va  = 1'b0;
    ena = 1'b1;
    put_a(0, -1, 3);
    put_a(0, 0, 3);
    repeat (5) step();

    // Reset: y_out first holds a nonzero value, then samples 1 and 0 are in
    // flight when reset is pulsed. Neither may ever appear.
    put_a(2, 2, 3);
    repeat (4) step();
    chk("hold_a_y2", int'(ya), 2);
    chk("hold_a_ov", int'(ova), 0);
    put_a(1, 0, -1);
    put_a(0, 0, -1);
    reset = 1'b0;
    #1;
    chk("rst_async_a_y", int'(ya), 0);
    chk("rst_async_a_ov", int'(ova), 0);
    step();
    step();
    reset = 1'b1;
    put_a(7, 7, 3);
    repeat (5) step();
    chk("hold_a_y7", int'(ya), 7);
    chk("hold_a_ov7", int'(ova), 0);

    // One stage, M=2: step of 5 on alternate cycles (the idle cycles carry
    // junk on x_in), then zeros back to back.
    put_b(5, 5, 1);
    xb = 16'd99; step();
    put_b(5, 5, 1);
    xb = 16'd99; step();
    put_b(5, 0, 1);
    xb = 16'd99; step();
    put_b(5, 0, 1);
    xb = 16'd99; step();
    put_b(0, -5, 1);
    put_b(0, -5, 1);
    put_b(0, 0, 1);
    repeat (3) step();

    // Wrap, 8 bits: 0x80 - 0 = 0x80; 0x7F - 0x80 = 0xFF
    put_c(8'h80, 8'h80, 1);
    put_c(8'h7F, 8'hFF, 1);
    repeat (2) step();

`ifdef CIC_COMB_FLUSH_EN
    // Flush while ena is low does nothing: the delay line still holds 0x7F.
    ena = 1'b0;
    flush = 1'b1;
    vc = 1'b1; xc = 8'd9;
    step();
    vc = 1'b0;
    flush = 1'b0;
    ena = 1'b1;
    put_c(8'h01, 8'h82, 1);
    repeat (2) step();
    // Flush wins over a coincident sample; the next sample sees a zero delay line.
    flush = 1'b1;
    put_c(9, 0, -1);
    flush = 1'b0;
    put_c(4, 4, 1);
    repeat (2) step();
`endif

    repeat (3) step();
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
